// File: rtl/tetris_pkg.sv
// Shared types for the Tetris display pipeline.
// Used by the pixel-set and matrix scan stages.
package tetris_pkg;

    localparam int MATRIX_DIM = 8;

    typedef logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] matrix_t;

    typedef enum logic {
        BLANK,
        ACTIVE
    } scan_state_t;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/matrix8x8_scan.sv
// Double-buffered 8x8 LED matrix row scanner.
// Frames swap only at the end of row 7, so a frame is never torn.
module matrix8x8_scan
    import tetris_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  matrix_t    frame_in,
    input  logic       frame_load,
    output logic [7:0] row_out,
    output logic [7:0] col_out,
    output logic       frame_start,
    output logic       frame_swapped
);

    localparam int CMAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] ACT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);

    localparam logic [7:0] ROW_OFF = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0] COL_OFF = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

    scan_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    row;
    matrix_t       active_buf;
    matrix_t       pend_buf;
    logic          pend_valid;
    logic          boundary;

    function automatic logic [7:0] row_drive(input logic [2:0] r);
        return ROW_ACTIVE_LOW ? ~onehot8(r) : onehot8(r);
    endfunction

    function automatic logic [7:0] col_drive(input logic [7:0] px);
        return COL_ACTIVE_LOW ? ~px : px;
    endfunction

    assign boundary = (state == ACTIVE) && (cnt == ACT_LAST) && (row == 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= BLANK;
            cnt           <= '0;
            row           <= '0;
            active_buf    <= '0;
            pend_buf      <= '0;
            pend_valid    <= 1'b0;
            row_out       <= ROW_OFF;
            col_out       <= COL_OFF;
            frame_start   <= 1'b0;
            frame_swapped <= 1'b0;
        end else begin
            frame_start   <= 1'b0;
            frame_swapped <= 1'b0;

            unique case (state)
                BLANK: begin
                    if (cnt == BLK_LAST) begin
                        state       <= ACTIVE;
                        cnt         <= '0;
                        row_out     <= row_drive(row);
                        col_out     <= col_drive(active_buf[row]);
                        frame_start <= (row == 3'd0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cnt == ACT_LAST) begin
                        state   <= BLANK;
                        cnt     <= '0;
                        row     <= row + 3'd1;
                        row_out <= ROW_OFF;
                        col_out <= COL_OFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase

            // A load landing on the boundary bypasses the pending buffer.
            if (boundary) begin
                if (frame_load) begin
                    active_buf <= frame_in;
                end else if (pend_valid) begin
                    active_buf <= pend_buf;
                end
                frame_swapped <= frame_load | pend_valid;
                pend_valid    <= 1'b0;
            end else if (frame_load) begin
                pend_buf   <= frame_in;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix8x8_scan.sv
// Self-checking bench for matrix8x8_scan.
// Expected outputs derive from the scan position within a 48-cycle frame.
module tb_matrix8x8_scan;
    import tetris_pkg::*;

    localparam int CD  = 4;
    localparam int BC  = 2;
    localparam int RP  = CD + BC;
    localparam int FP  = 8 * RP;

    logic       clk;
    logic       reset_n;
    matrix_t    frame_in;
    logic       frame_load;
    logic [7:0] row_out;
    logic [7:0] col_out;
    logic       frame_start;
    logic       frame_swapped;

    int n_chk  = 0;
    int n_pass = 0;

    matrix8x8_scan #(
        .CLK_DIV       (CD),
        .BLANK_CYCLES  (BC),
        .ROW_ACTIVE_LOW(1'b1),
        .COL_ACTIVE_LOW(1'b0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_in     (frame_in),
        .frame_load   (frame_load),
        .row_out      (row_out),
        .col_out      (col_out),
        .frame_start  (frame_start),
        .frame_swapped(frame_swapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: c = cycles since reset release; displayed frame in act.
    int      c;
    matrix_t act;
    matrix_t pend;
    logic    pv;
    logic    sw;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c    <= 0;
            act  <= '0;
            pend <= '0;
            pv   <= 1'b0;
            sw   <= 1'b0;
        end else begin
            c <= c + 1;
            if (c % FP == FP - 1) begin
                if (frame_load) act <= frame_in;
                else if (pv)    act <= pend;
                pv <= 1'b0;
                sw <= frame_load | pv;
            end else begin
                sw <= 1'b0;
                if (frame_load) begin
                    pend <= frame_in;
                    pv   <= 1'b1;
                end
            end
        end
    end

    int         cyc = 0;
    int         last_fs = -1;
    int         pos, rr, qq;
    logic [7:0] er, ec;

    always @(negedge clk) begin
        cyc++;
        pos = c % FP;
        rr  = pos / RP;
        qq  = pos % RP;
        if (qq >= BC) begin
            er = ~(8'd1 << rr);
            ec = act[rr];
        end else begin
            er = 8'hFF;
            ec = 8'h00;
        end
        chk("row_out", row_out, er);
        chk("col_out", col_out, ec);
        chk("frame_start", frame_start, pos == BC);
        chk("frame_swapped", frame_swapped, sw);
        if (!reset_n) begin
            last_fs = -1;
        end else if (frame_start) begin
            if (last_fs >= 0) chk("fs_period", cyc - last_fs, FP);
            last_fs = cyc;
        end
    end

    function automatic matrix_t rnd_frame();
        return {$urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_in = rnd_frame();
        end
    endtask

    task automatic wait_pos(input int tgt);
        for (int i = 0; i < 2 * FP; i++) begin
            @(negedge clk);
            frame_in = rnd_frame();
            if (c % FP == tgt) return;
        end
        chk("wait_timeout", 0, 1);
    endtask

    task automatic load(input matrix_t m);
        frame_in   = m;
        frame_load = 1'b1;
        @(negedge clk);
        frame_load = 1'b0;
        frame_in   = rnd_frame();
    endtask

    matrix_t m;

    initial begin
        reset_n    = 1'b0;
        frame_load = 1'b0;
        frame_in   = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(FP + 3);

        // single load mid row 2, swap at boundary
        wait_pos(14);
        m = '0; m[3] = 8'hA5;
        load(m);
        idle(FP + 10);

        // last write wins
        wait_pos(5);
        m = '0; m[0] = 8'h01;
        load(m);
        wait_pos(20);
        m = '0; m[0] = 8'h80;
        load(m);
        idle(FP + 10);

        // load on the boundary cycle bypasses pending
        wait_pos(FP - 1);
        m = '0; m[0] = 8'h3C;
        load(m);
        idle(3 * FP);

        // reset during row 5 with a pending frame
        wait_pos(10);
        load(rnd_frame());
        wait_pos(5 * RP + BC);
        #2 reset_n = 1'b0;
        #1;
        chk("async_row", row_out, 8'hFF);
        chk("async_col", col_out, 8'h00);
        chk("async_fs", frame_start, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(2 * FP);

        // random loads at random phases
        for (int i = 0; i < 30; i++) begin
            idle($urandom_range(1, 70));
            load(rnd_frame());
        end
        idle(2 * FP);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/matrix8x8_scan.md
Name: matrix8x8_scan

Overview:
Downstream display stage for the 8x8 Tetris frame. It takes the composed 8x8 matrix from the pixel-set stage and double-buffers it. It then time-multiplexes the active frame onto the physical LED matrix one row at a time, with a blanking gap between rows. Frame swaps happen only at frame boundaries, so the display never shows tearing.

Parameters:
CLK_DIV, 1000, clk cycles each row is lit (ACTIVE dwell); legal range >=1
BLANK_CYCLES, 16, clk cycles all rows/cols are off between rows; legal range >=1
ROW_ACTIVE_LOW, 1, 1: the selected row drives 0, others drive 1; 0: inverse
COL_ACTIVE_LOW, 0, 1: a lit pixel drives 0 on its column; 0: a lit pixel drives 1

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
frame_in  input  [7:0][7:0]  new frame; frame_in[y][x] = pixel (x,y), 1 = lit
frame_load  input  1  1-cycle strobe; capture frame_in into the pending buffer
row_out  output  8  row drivers; bit r selects matrix row r
col_out  output  8  column drivers; bit x = pixel (x, current row)
frame_start  output  1  1-cycle pulse on the first ACTIVE cycle of row 0
frame_swapped  output  1  1-cycle pulse in the cycle the pending buffer becomes active

Behaviour:
- All outputs are registered. Asynchronous reset (reset_n=0) sets:
  - active, pending buffers = 0; pending_valid = 0; row = 0; state = BLANK; cnt = 0
  - row_out, col_out = inactive levels (all rows off, all cols off, per polarity params)
  - frame_start = frame_swapped = 0
- States:
  - BLANK: outputs inactive. cnt counts 0..BLANK_CYCLES-1. On the last count -> ACTIVE, cnt = 0.
  - ACTIVE: row_out selects `row`; col_out = active[row], polarity applied. cnt counts 0..CLK_DIV-1. On the last count -> BLANK, cnt = 0, row = row+1 mod 8 (7 wraps to 0).
- Frame boundary = the cycle ACTIVE ends with row = 7.
- frame_start asserts for exactly one cycle, coincident with the first ACTIVE output cycle of row 0.
- Frame period = 8*(CLK_DIV+BLANK_CYCLES) cycles. After reset, row 0 lights BLANK_CYCLES cycles after reset_n deasserts.
- frame_load without a boundary: pending <= frame_in, pending_valid <= 1. A later load before the boundary overwrites pending (last write wins).
- Boundary with pending_valid = 1: active <= pending, pending_valid <= 0, frame_swapped pulses in the next cycle.
- Boundary and frame_load in the same cycle: active <= frame_in directly (bypass), pending_valid <= 0, frame_swapped pulses.
- Boundary with no pending and no load: active is unchanged; no pulse.
- Changing frame_in while frame_load is low has no effect.
- Reset mid-frame: immediate return to reset state; pending content is discarded.
- Row and column bits are never active during BLANK, so there is no ghosting.

Decomposition:
- tetris_pkg contains:
  - typedef matrix_t = logic [7:0][7:0], shared with the pixel-set stage
  - typedef scan_state_t enum {BLANK, ACTIVE}
  - constant MATRIX_DIM = 8
- No sub-module needed. The counter, FSM and buffers fit in one module of about 150 lines.

Test Plan (CLK_DIV=4, BLANK_CYCLES=2, ROW_ACTIVE_LOW=1, COL_ACTIVE_LOW=0, period 48):
- Reset/first row:
  - Stimulus: hold reset_n=0, release.
  - Response: row_out=8'hFF and col_out=8'h00 for 2 cycles; then row_out=8'hFE, col_out=8'h00, frame_start=1 for one cycle; row 0 stays lit 4 cycles.
- Load and swap:
  - Stimulus: frame_load with frame_in[3]=8'hA5, all other rows 0, mid row 2 of frame N.
  - Response: row 3 shows col_out=8'h00 in frame N. frame_swapped pulses once after row 7 ACTIVE ends. In frame N+1, row 3 shows row_out=8'hF7, col_out=8'hA5.
- Last write wins:
  - Stimulus: load frame_in[0]=8'h01, then frame_in[0]=8'h80, both before the boundary.
  - Response: next frame row 0 col_out=8'h80; exactly one frame_swapped pulse.
- Simultaneous boundary and load:
  - Stimulus: frame_load in the last ACTIVE cycle of row 7 with frame_in[0]=8'h3C.
  - Response: frame_swapped pulses; the immediately following row 0 shows col_out=8'h3C.
- Wrap and timing:
  - Stimulus: run 3 frames.
  - Response: frame_start pulses exactly every 48 cycles; row_out sequence FE,FD,FB,F7,EF,DF,BF,7F, with FF during each 2-cycle blank.
- Reset mid-operation:
  - Stimulus: load a pending frame, then assert reset_n=0 during row 5.
  - Response: outputs go inactive asynchronously; after release, row 0 shows col_out=8'h00; no frame_swapped pulse.
